// File: rtl/mem_bank_1r1w_init.sv
// Single-read, single-write register bank with a hardware init sweep.
// The array has no reset; every entry is loaded with INIT_VALUE by the sweep after reset or clear.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | sweeping INIT_VALUE into entry sweep_ptr, ports ignored
// ST_IDLE | sweep done, W0/R0 accepted, clear starts a new sweep
module mem_bank_1r1w_init #(
  parameter int unsigned          REG_DEPTH   = 16,
  parameter int unsigned          REG_WIDTH   = 64,
  parameter bit                   WRITE_FIRST = 1'b1,
  parameter logic [REG_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  output logic                         ready,
  input  logic                         W0_en,
  input  logic [$clog2(REG_DEPTH)-1:0] W0_addr,
  input  logic [REG_WIDTH-1:0]         W0_wmask,
  input  logic [REG_WIDTH-1:0]         W0_wdata,
  input  logic                         R0_en,
  input  logic [$clog2(REG_DEPTH)-1:0] R0_addr,
  output logic                         R0_valid,
  output logic [REG_WIDTH-1:0]         R0_rdata
);

  localparam int unsigned    AW      = $clog2(REG_DEPTH);
  localparam logic [AW:0]    DEPTH_C = REG_DEPTH[AW:0];
  localparam logic [AW-1:0]  LAST_C  = AW'(REG_DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t               state;
  logic [AW-1:0]        sweep_ptr;
  logic [REG_WIDTH-1:0] mem [REG_DEPTH];

  logic                 w_in_range;
  logic                 r_in_range;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [REG_WIDTH-1:0] wr_merged;
  logic [REG_WIDTH-1:0] rd_next;

  assign ready      = (state == ST_IDLE);
  assign w_in_range = ({1'b0, W0_addr} < DEPTH_C);
  assign r_in_range = ({1'b0, R0_addr} < DEPTH_C);
  assign wr_acc     = ready & W0_en & w_in_range;
  assign rd_acc     = ready & R0_en;
  assign wr_merged  = (mem[W0_addr] & ~W0_wmask) | (W0_wdata & W0_wmask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      sweep_ptr <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          // clear wins over completion so a clear on the last sweep edge still restarts
          if (clear) begin
            sweep_ptr <= '0;
          end else if (sweep_ptr == LAST_C) begin
            state     <= ST_IDLE;
            sweep_ptr <= '0;
          end else begin
            sweep_ptr <= sweep_ptr + AW'(1);
          end
        end
        ST_IDLE: begin
          if (clear) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
          end
        end
        default: begin
          state     <= ST_INIT;
          sweep_ptr <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[sweep_ptr] <= INIT_VALUE;
    end else if (wr_acc) begin
      mem[W0_addr] <= wr_merged;
    end
  end

  always_comb begin
    rd_next = '0;
    if (r_in_range) begin
      rd_next = mem[R0_addr];
      if (WRITE_FIRST && wr_acc && (W0_addr == R0_addr)) begin
        rd_next = wr_merged;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      R0_valid <= 1'b0;
      R0_rdata <= '0;
    end else begin
      R0_valid <= rd_acc;
      if (rd_acc) begin
        R0_rdata <= rd_next;
      end
    end
  end

endmodule

// File: tb/tb_mem_bank_1r1w_init.sv
// Drives three banks in lockstep (depth 4 write-first, depth 4 read-first, depth 6 write-first)
// and compares every cycle against an array model with a sweep-countdown per bank.
module tb_mem_bank_1r1w_init;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       w_en;
  logic [2:0] w_addr;
  logic [7:0] w_mask;
  logic [7:0] w_data;
  logic       r_en;
  logic [2:0] r_addr;

  logic [2:0] rdy;
  logic [2:0] vld;
  logic [7:0] rd [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] m_mem  [3][8];
  int         m_busy [3];
  logic       m_vld  [3];
  logic [7:0] m_rd   [3];

  mem_bank_1r1w_init #(.REG_DEPTH(4), .REG_WIDTH(8), .WRITE_FIRST(1'b1), .INIT_VALUE(8'hA5)) u_wf (
    .clk(clk), .reset_n(reset_n), .clear(clear), .ready(rdy[0]),
    .W0_en(w_en), .W0_addr(w_addr[1:0]), .W0_wmask(w_mask), .W0_wdata(w_data),
    .R0_en(r_en), .R0_addr(r_addr[1:0]), .R0_valid(vld[0]), .R0_rdata(rd[0]));

  mem_bank_1r1w_init #(.REG_DEPTH(4), .REG_WIDTH(8), .WRITE_FIRST(1'b0), .INIT_VALUE(8'hA5)) u_rf (
    .clk(clk), .reset_n(reset_n), .clear(clear), .ready(rdy[1]),
    .W0_en(w_en), .W0_addr(w_addr[1:0]), .W0_wmask(w_mask), .W0_wdata(w_data),
    .R0_en(r_en), .R0_addr(r_addr[1:0]), .R0_valid(vld[1]), .R0_rdata(rd[1]));

  mem_bank_1r1w_init #(.REG_DEPTH(6), .REG_WIDTH(8), .WRITE_FIRST(1'b1), .INIT_VALUE(8'hA5)) u_odd (
    .clk(clk), .reset_n(reset_n), .clear(clear), .ready(rdy[2]),
    .W0_en(w_en), .W0_addr(w_addr), .W0_wmask(w_mask), .W0_wdata(w_data),
    .R0_en(r_en), .R0_addr(r_addr), .R0_valid(vld[2]), .R0_rdata(rd[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dep(input int i);
    return (i == 2) ? 6 : 4;
  endfunction

  function automatic bit wf(input int i);
    return (i != 1);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_ready%0d", tag, i), {7'b0, rdy[i]}, {7'b0, (m_busy[i] == 0)});
      chk($sformatf("%s_valid%0d", tag, i), {7'b0, vld[i]}, {7'b0, m_vld[i]});
      chk($sformatf("%s_rdata%0d", tag, i), rd[i], m_rd[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = dep(i);
      m_vld[i]  = 1'b0;
      m_rd[i]   = 8'h00;
    end
  endtask

  task automatic model_edge(input logic clr, input logic we, input logic [2:0] wa,
                            input logic [7:0] wm, input logic [7:0] wd,
                            input logic re, input logic [2:0] ra);
    for (int i = 0; i < 3; i++) begin
      int d;
      int aw;
      int ar;
      bit acc;
      d   = dep(i);
      aw  = (i == 2) ? int'(wa) : int'(wa[1:0]);
      ar  = (i == 2) ? int'(ra) : int'(ra[1:0]);
      acc = (m_busy[i] == 0);
      m_vld[i] = acc && re;
      if (acc && re) begin
        if (ar >= d)                      m_rd[i] = 8'h00;
        else if (wf(i) && we && aw == ar) m_rd[i] = (m_mem[i][ar] & ~wm) | (wd & wm);
        else                              m_rd[i] = m_mem[i][ar];
      end
      if (acc && we && aw < d) m_mem[i][aw] = (m_mem[i][aw] & ~wm) | (wd & wm);
      if (clr) begin
        m_busy[i] = d;
      end else if (m_busy[i] > 0) begin
        m_busy[i]--;
        if (m_busy[i] == 0)
          for (int j = 0; j < 8; j++) m_mem[i][j] = 8'hA5;
      end
    end
  endtask

  // called positioned on a negedge; returns on the next negedge
  task automatic tick(input logic clr, input logic we, input logic [2:0] wa,
                      input logic [7:0] wm, input logic [7:0] wd,
                      input logic re, input logic [2:0] ra);
    clear = clr; w_en = we; w_addr = wa; w_mask = wm; w_data = wd; r_en = re; r_addr = ra;
    @(posedge clk);
    model_edge(clr, we, wa, wm, wd, re, ra);
    #1;
    cyc++;
    check_all($sformatf("c%0d", cyc));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
  endtask

  task automatic rd_tick(input logic [2:0] a);
    tick(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, a);
  endtask

  task automatic pulse_reset();
    clear = 1'b0; w_en = 1'b0; r_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all($sformatf("rst%0d", cyc));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    clear = 1'b0; w_en = 1'b0; w_addr = '0; w_mask = '0; w_data = '0; r_en = 1'b0; r_addr = '0;
    model_reset();
    #3;
    check_all("por");
    @(negedge clk);
    reset_n = 1'b1;

    // initial sweep: depth-4 banks ready after 4 edges, depth-6 after 6
    idle(6);
    for (int a = 0; a < 4; a++) rd_tick(3'(a));
    chk("init_read3", rd[0], 8'hA5);
    idle(1);

    // masked write then read back
    tick(1'b0, 1'b1, 3'd2, 8'h0F, 8'h3C, 1'b0, 3'd0);
    rd_tick(3'd2);
    chk("masked_wr", rd[0], 8'hAC);

    // same-cycle collision on address 1
    tick(1'b0, 1'b1, 3'd1, 8'hFF, 8'hFF, 1'b1, 3'd1);
    chk("coll_wf", rd[0], 8'hFF);
    chk("coll_rf", rd[1], 8'hA5);
    rd_tick(3'd1);
    chk("coll_rf_after", rd[1], 8'hFF);

    // different-address read and write in the same cycle
    tick(1'b0, 1'b1, 3'd3, 8'hF0, 8'h5A, 1'b1, 3'd2);
    rd_tick(3'd3);

    // clear in IDLE, writes during the sweep are ignored
    tick(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
    repeat (4) tick(1'b0, 1'b1, 3'd0, 8'hFF, 8'h00, 1'b1, 3'd0);
    idle(2);
    for (int a = 0; a < 4; a++) rd_tick(3'(a));
    rd_tick(3'd0);
    chk("clear_swept", rd[0], 8'hA5);

    // clear re-asserted mid-sweep
    tick(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
    idle(2);
    tick(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
    idle(6);

    // out-of-range addresses on the depth-6 bank (alias to 2/3 on depth-4 banks)
    tick(1'b0, 1'b1, 3'd6, 8'hFF, 8'h11, 1'b1, 3'd6);
    tick(1'b0, 1'b1, 3'd7, 8'hFF, 8'h22, 1'b1, 3'd7);
    chk("oor_rd", rd[2], 8'h00);
    for (int a = 0; a < 6; a++) rd_tick(3'(a));

    // reset mid-sweep
    tick(1'b0, 1'b1, 3'd0, 8'hFF, 8'h77, 1'b0, 3'd0);
    tick(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
    idle(2);
    pulse_reset();
    idle(6);
    rd_tick(3'd0);
    chk("rst_sweep", rd[0], 8'hA5);

    // randomized traffic with occasional clear and reset
    repeat (500) begin
      logic [2:0] wa;
      logic [2:0] ra;
      wa = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) pulse_reset();
      tick(($urandom_range(0, 29) == 0), 1'($urandom), wa, 8'($urandom), 8'($urandom),
           1'($urandom), ra);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
